// File: rtl/hyster_scan_ctrl.sv
// Raster scan controller feeding a 3-row hysteresis stage and writing its edge bits.
// Latency: reads pipelined 1 cycle to the stage; writes issue the same cycle as stg_rdy.
// No backpressure: reads stream at one column per cycle, stage results are taken whenever valid.
module hyster_scan_ctrl #(
   parameter int IMG_W = 960,
   parameter int IMG_H = 720,
   parameter int PIX_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             rd_en,
   output logic [9:0]       rd_row,
   output logic [9:0]       rd_col,
   input  logic [PIX_W-1:0] rd_data0,
   input  logic [PIX_W-1:0] rd_data1,
   input  logic [PIX_W-1:0] rd_data2,
   output logic             stg_clr,
   output logic             stg_en,
   output logic [PIX_W-1:0] stg_pix0,
   output logic [PIX_W-1:0] stg_pix1,
   output logic [PIX_W-1:0] stg_pix2,
   input  logic             stg_out,
   input  logic             stg_rdy,
   output logic             wr_en,
   output logic [19:0]      wr_addr,
   output logic             wr_bit
);

   typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, NEXT, DONE} state_t;

   localparam logic [9:0] LAST_COL = 10'(IMG_W - 1);
   localparam logic [9:0] WR_LAST  = 10'(IMG_W - 2);
   localparam logic [9:0] LAST_ROW = 10'(IMG_H - 2);

   state_t     state, state_nxt;
   logic [9:0] row_q;
   logic [9:0] col_q;
   logic [9:0] wr_col_q;
   logic [1:0] drain_q;
   logic       wr_window;

   // State register; reset aborts any frame in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic: one CLR/RUN/DRAIN/NEXT pass per interior row.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = CLR;
         CLR:   state_nxt = RUN;
         RUN:   if (col_q == LAST_COL) state_nxt = DRAIN;
         DRAIN: if (drain_q == 2'd2) state_nxt = NEXT;
         NEXT:  state_nxt = (row_q == LAST_ROW) ? DONE : CLR;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Row, read-column, write-column and drain counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_q    <= '0;
         col_q    <= '0;
         wr_col_q <= '0;
         drain_q  <= '0;
      end else begin
         case (state)
            IDLE:  if (start) row_q <= 10'd1;
            CLR: begin
               col_q    <= '0;
               wr_col_q <= 10'd1;
               drain_q  <= '0;
            end
            RUN:   if (col_q != LAST_COL) col_q <= col_q + 10'd1;
            DRAIN: drain_q <= drain_q + 2'd1;
            NEXT:  if (row_q != LAST_ROW) row_q <= row_q + 10'd1;
            default: ;
         endcase
         // wr_en is never high in CLR, so this cannot collide with the load above.
         if (wr_en) wr_col_q <= wr_col_q + 10'd1;
      end
   end

   // Stage enable follows the read request by one cycle, matching read data latency.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) stg_en <= 1'b0;
      else       stg_en <= rd_en;
   end

   // Stage results are only accepted while a row is active; the column limit
   // keeps column 0 and column IMG_W-1 from ever being written.
   always_comb begin
      wr_window = (state == RUN) || (state == DRAIN) || (state == NEXT);
      wr_en     = wr_window && stg_rdy && (wr_col_q <= WR_LAST);
      wr_bit    = wr_en & stg_out;
      wr_addr   = 20'(row_q) * 20'(IMG_W) + 20'(wr_col_q);
   end

   assign busy     = (state == CLR) || (state == RUN) || (state == DRAIN) || (state == NEXT);
   assign done     = (state == DONE);
   assign stg_clr  = (state == CLR);
   assign rd_en    = (state == RUN);
   assign rd_row   = row_q;
   assign rd_col   = col_q;
   assign stg_pix0 = rd_data0;
   assign stg_pix1 = rd_data1;
   assign stg_pix2 = rd_data2;

endmodule

// File: doc/hyster_scan_ctrl.md
HYSTER_SCAN_CTRL -- requirements
Module: hyster_scan_ctrl

Interface
REQ-001 The block SHALL have parameter IMG_W, default 960, meaning image width in pixels.
REQ-002 The block SHALL have parameter IMG_H, default 720, meaning image height in pixels.
REQ-003 The block SHALL have parameter PIX_W, default 5, meaning bits per pixel.
REQ-004 The block SHALL have port clk, input, 1, meaning rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1, meaning a single-cycle request to process one frame.
REQ-007 The block SHALL have port busy, output, 1, meaning a frame is in progress.
REQ-008 The block SHALL have port done, output, 1, meaning a one-cycle pulse marking frame complete.
REQ-009 The block SHALL have ports rd_en (output, 1), rd_row (output, 10) and rd_col (output, 10), meaning a read request for rows rd_row-1, rd_row and rd_row+1 at column rd_col.
REQ-010 The block SHALL have ports rd_data0, rd_data1 and rd_data2 (input, PIX_W each), meaning the three row pixels, valid exactly 1 cycle after rd_en.
REQ-011 The block SHALL have ports stg_clr (output, 1), stg_en (output, 1) and stg_pix0, stg_pix1, stg_pix2 (output, PIX_W each), meaning clear, enable and column data for the hysteresis stage.
REQ-012 The block SHALL have ports stg_out (input, 1) and stg_rdy (input, 1), meaning the stage edge bit and its valid flag.
REQ-013 The block SHALL have ports wr_en (output, 1), wr_addr (output, 20) and wr_bit (output, 1), meaning the edge-map write port with address row*IMG_W+col.

Function
REQ-014 The FSM SHALL have states IDLE, CLR, RUN, DRAIN, NEXT and DONE, and SHALL be in IDLE after reset.
REQ-015 In IDLE, start=1 SHALL move the FSM to CLR, set busy=1 on the next cycle, and load the row counter with 1.
REQ-016 start SHALL be ignored in every state other than IDLE.
REQ-017 CLR SHALL last exactly 1 cycle with stg_clr=1, then move to RUN with the column counter at 0.
REQ-018 RUN SHALL assert rd_en for exactly IMG_W consecutive cycles with rd_col = 0..IMG_W-1 and rd_row = the row counter, then move to DRAIN.
REQ-019 stg_en SHALL be rd_en delayed by 1 register stage.
REQ-020 stg_pix0, stg_pix1 and stg_pix2 SHALL equal rd_data0, rd_data1 and rd_data2 combinationally.
REQ-021 The write column counter SHALL be set to 1 in CLR.
REQ-022 On each cycle with stg_rdy=1 and write column <= IMG_W-2, the block SHALL drive wr_en=1, wr_bit=stg_out and wr_addr=row*IMG_W+wr_col, then increment wr_col.
REQ-023 stg_rdy cycles with write column > IMG_W-2 SHALL be discarded with wr_en=0.
REQ-024 Border pixels (row 0, row IMG_H-1, col 0, col IMG_W-1) SHALL never be written.
REQ-025 DRAIN SHALL last exactly 3 cycles and then move to NEXT, regardless of the number of writes performed.
REQ-026 NEXT SHALL last 1 cycle: if row == IMG_H-2 the FSM SHALL go to DONE, otherwise it SHALL increment row and go to CLR.
REQ-027 DONE SHALL last 1 cycle with done=1 and busy=0, then return to IDLE.
REQ-028 busy SHALL be 1 in CLR, RUN, DRAIN and NEXT, and 0 otherwise.
REQ-029 wr_addr SHALL be computed at the full 20-bit width with no truncation for IMG_W*IMG_H <= 2^20.

Reset
REQ-030 Assertion of reset SHALL immediately force the FSM to IDLE, all counters to 0, and busy, done, rd_en, stg_en, stg_clr and wr_en to 0, with rd_row, rd_col and wr_addr at 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no done pulse, and no write SHALL occur after reset is asserted.
REQ-032 After reset is released, the block SHALL stay in IDLE until the next start.

Verification (IMG_W=8, IMG_H=5)
REQ-033 Reset, then a start pulse -> busy=1 one cycle later, one stg_clr pulse, and rd_en high for 8 cycles with rd_col=0..7 and rd_row=1.
REQ-034 A full frame -> rows 1..3 processed, done pulses once exactly 1 cycle after the last NEXT, and busy=0 in that cycle.
REQ-035 Stage model asserting stg_rdy for 10 cycles on a row -> exactly 6 writes with wr_addr=row*8+1 .. row*8+6, and the rest discarded.
REQ-036 start pulsed again while busy -> no effect, and the frame completes with a single done.
REQ-037 Reset asserted during RUN of row 2 -> all outputs 0 immediately, no done; a later start restarts at row 1.
REQ-038 stg_out driven as a known pattern -> wr_bit matches stg_out on every write cycle, and there are 18 writes in total per frame.
